// File: rtl/block_interleaver.sv
// Row/column block interleaver: frames of ROWS*COLS symbols written row-wise into a
// ping-pong buffer and read column-wise. Deinterleave mode is built with BLKINTLV_DEINT_EN.
module block_interleaver #(
    parameter int DATA_W = 1,
    parameter int ROWS   = 2,
    parameter int COLS   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              deint,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int N  = ROWS * COLS;
    localparam int AW = $clog2(N);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [AW-1:0] LAST_A   = AW'(N - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [AW-1:0] COLS_A   = AW'(COLS);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } rd_state_t;

    logic [DATA_W-1:0] mem_r [2][N];
    logic [1:0]        full_r;
    logic [1:0]        mode_s;
    logic              wr_bank_r;
    logic              rd_bank_r;
    logic [AW-1:0]     j_r;
    logic [AW-1:0]     k_r;
    logic [RW-1:0]     rd_row_r;
    logic [CW-1:0]     rd_col_r;
    logic [AW-1:0]     wr_addr_s;
    logic [AW-1:0]     rd_addr_s;
    logic              wr_fire_s;
    logic              rd_fire_s;
    logic              load_s;
    rd_state_t         state_r;
    rd_state_t         state_nxt_s;

    assign in_ready  = ~full_r[wr_bank_r];
    assign wr_fire_s = in_valid & ~full_r[wr_bank_r];
    assign load_s    = ~out_valid | out_ready;

`ifdef BLKINTLV_DEINT_EN
    logic [1:0]    mode_r;
    logic [RW-1:0] wr_row_r;
    logic [CW-1:0] wr_col_r;
    logic          wr_mode_s;

    // Write address: the first symbol of a frame takes its mode directly from deint.
    always_comb begin
        wr_mode_s = 1'b0;
        wr_addr_s = j_r;
        if (j_r == '0) begin
            wr_mode_s = deint;
        end else begin
            wr_mode_s = mode_r[wr_bank_r];
        end
        if (wr_mode_s) begin
            wr_addr_s = AW'(wr_row_r) * COLS_A + AW'(wr_col_r);
        end else begin
            wr_addr_s = j_r;
        end
    end

    // Per-bank mode latch and transposed write position (row = j mod ROWS, col = j / ROWS).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_r   <= 2'b00;
            wr_row_r <= '0;
            wr_col_r <= '0;
        end else if (wr_fire_s) begin
            if (j_r == '0) begin
                mode_r[wr_bank_r] <= deint;
            end
            if (j_r == LAST_A) begin
                wr_row_r <= '0;
                wr_col_r <= '0;
            end else if (wr_row_r == LAST_ROW) begin
                wr_row_r <= '0;
                wr_col_r <= wr_col_r + CW'(1);
            end else begin
                wr_row_r <= wr_row_r + RW'(1);
            end
        end
    end

    assign mode_s = mode_r;
`else
    logic unused_deint_s;

    assign unused_deint_s = deint;
    assign mode_s         = 2'b00;
    assign wr_addr_s      = j_r;
`endif

    // Interleave reads column-major; deinterleave data was already transposed on write.
    always_comb begin
        rd_addr_s = AW'(rd_row_r) * COLS_A + AW'(rd_col_r);
        if (mode_s[rd_bank_r]) begin
            rd_addr_s = k_r;
        end else begin
            rd_addr_s = AW'(rd_row_r) * COLS_A + AW'(rd_col_r);
        end
    end

    // Symbol storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_bank_r][wr_addr_s] <= in_data;
        end
    end

    // Read FSM: reading may start in IDLE so a freshly filled bank drains with no bubble.
    always_comb begin
        state_nxt_s = state_r;
        rd_fire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (full_r[rd_bank_r]) begin
                    state_nxt_s = ST_DRAIN;
                    rd_fire_s   = load_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                rd_fire_s = load_s;
                if (load_s && (k_r == LAST_A)) begin
                    state_nxt_s = full_r[~rd_bank_r] ? ST_DRAIN : ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                rd_fire_s   = 1'b0;
            end
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame bookkeeping: counters, bank pointers and full flags (the two sides never share a bank).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_r    <= 2'b00;
            wr_bank_r <= 1'b0;
            rd_bank_r <= 1'b0;
            j_r       <= '0;
            k_r       <= '0;
            rd_row_r  <= '0;
            rd_col_r  <= '0;
        end else begin
            if (wr_fire_s) begin
                if (j_r == LAST_A) begin
                    j_r               <= '0;
                    full_r[wr_bank_r] <= 1'b1;
                    wr_bank_r         <= ~wr_bank_r;
                end else begin
                    j_r <= j_r + AW'(1);
                end
            end
            if (rd_fire_s) begin
                if (k_r == LAST_A) begin
                    k_r               <= '0;
                    rd_row_r          <= '0;
                    rd_col_r          <= '0;
                    full_r[rd_bank_r] <= 1'b0;
                    rd_bank_r         <= ~rd_bank_r;
                end else begin
                    k_r <= k_r + AW'(1);
                    if (rd_row_r == LAST_ROW) begin
                        rd_row_r <= '0;
                        rd_col_r <= rd_col_r + CW'(1);
                    end else begin
                        rd_row_r <= rd_row_r + RW'(1);
                    end
                end
            end
        end
    end

    // Output register: holds while the consumer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (rd_fire_s) begin
            out_data  <= mem_r[rd_bank_r][rd_addr_s];
            out_valid <= 1'b1;
            out_last  <= (k_r == LAST_A);
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_block_interleaver.sv
// Self-checking bench for block_interleaver: a 2x4 instance for the legacy permutation,
// backpressure and reset cases, and a 3x5 instance for back-to-back streaming.
module tb_block_interleaver;

    localparam int RA = 2;
    localparam int CA = 4;
    localparam int NA = RA * CA;
    localparam int RB = 3;
    localparam int CB = 5;
    localparam int NB = RB * CB;
`ifdef BLKINTLV_DEINT_EN
    localparam bit DEINT_ON = 1'b1;
`else
    localparam bit DEINT_ON = 1'b0;
`endif

    typedef logic [7:0] sym_q_t [$];

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [7:0] a_in_data, a_out_data;
    logic       a_in_valid, a_in_ready, a_deint, a_out_valid, a_out_last;
    logic       a_out_ready = 1'b1;
    logic       a_bp_en = 1'b0;
    logic       a_rdy_force = 1'b1;
    logic [7:0] b_in_data, b_out_data;
    logic       b_in_valid, b_in_ready, b_deint, b_out_valid, b_out_last;
    logic       b_out_ready = 1'b1;

    logic [7:0] qa_d[$];
    logic       qa_l[$];
    logic [7:0] qb_d[$];
    logic       qb_l[$];
    int         qb_c[$];

    block_interleaver #(.DATA_W(8), .ROWS(RA), .COLS(CA)) u_dut_a (
        .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .deint(a_deint), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_last(a_out_last)
    );

    block_interleaver #(.DATA_W(8), .ROWS(RB), .COLS(CB)) u_dut_b (
        .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .deint(b_deint), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_last(b_out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        a_out_ready = a_bp_en ? 1'($urandom_range(0, 1)) : a_rdy_force;
    end

    // Transfers complete at the next rising edge; inputs are stable from the falling edge on.
    always @(negedge clk) begin
        if (reset && a_out_valid && a_out_ready) begin
            qa_d.push_back(a_out_data);
            qa_l.push_back(a_out_last);
        end
        if (reset && b_out_valid && b_out_ready) begin
            qb_d.push_back(b_out_data);
            qb_l.push_back(b_out_last);
            qb_c.push_back(cyc);
        end
    end

    // Reference: interleave reads element (k mod R)*C + k/R; deinterleave scatters to it.
    function automatic sym_q_t model(sym_q_t d, int r, int c, bit m);
        sym_q_t e;
        e = d;
        for (int j = 0; j < r * c; j++) begin
            if (m) e[(j % r) * c + j / r] = d[j];
            else   e[j] = d[(j % r) * c + j / r];
        end
        return e;
    endfunction

    task automatic a_send(input logic [7:0] d, input logic dm);
        int w = 0;
        a_in_data = d; a_in_valid = 1'b1; a_deint = dm;
        @(negedge clk);
        while (!a_in_ready && w < 300) begin @(negedge clk); w++; end
        n_checks++;
        if (w >= 300) begin n_fail++; $display("FAIL a_accept_timeout got in_ready=0 required 1"); end
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_deint = 1'b0;
    endtask

    task automatic a_frame(input sym_q_t d, input bit dm);
        for (int i = 0; i < NA; i++) a_send(d[i], (i == 0) ? dm : 1'($urandom_range(0, 1)));
    endtask

    task automatic a_wait(input int n, output bit to);
        int t = 0;
        while (qa_d.size() < n && t < 2000) begin @(negedge clk); t++; end
        to = (qa_d.size() < n);
    endtask

    task automatic a_settle();
        a_bp_en = 1'b0; a_rdy_force = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        qa_d.delete(); qa_l.delete();
    endtask

    task automatic b_send(input logic [7:0] d, output int w);
        w = 0;
        b_in_data = d; b_in_valid = 1'b1;
        @(negedge clk);
        while (!b_in_ready && w < 300) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b required 0", a_out_valid); end
        n_checks++; if (a_out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last got %b required 0", a_out_last); end
        n_checks++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h required 00", a_out_data); end
        n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b required 1", a_in_ready); end
        n_checks++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b got ready=%b valid=%b required 1/0", b_in_ready, b_out_valid); end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_interleave();
        sym_q_t d, e, x;
        logic [7:0] perm [NA] = '{8'd0, 8'd4, 8'd1, 8'd5, 8'd2, 8'd6, 8'd3, 8'd7};
        bit to;
        bit dm;
        a_settle();
        for (int i = 0; i < NA; i++) a_send(8'(i), 1'b0);
        n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL latency_early got out_valid=%b required 0", a_out_valid); end
        @(posedge clk); #1;
        n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'd0) begin n_fail++; $display("FAIL latency_first got valid=%b data=%h required 1/00", a_out_valid, a_out_data); end
        a_wait(NA, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL interleave_count got %0d required %0d", qa_d.size(), NA); end
        else for (int k = 0; k < NA; k++) begin
            n_checks++; if (qa_d[k] !== perm[k]) begin n_fail++; $display("FAIL interleave_data k=%0d got %h required %h", k, qa_d[k], perm[k]); end
            n_checks++; if (qa_l[k] !== (k == NA - 1)) begin n_fail++; $display("FAIL interleave_last k=%0d got %b required %b", k, qa_l[k], k == NA - 1); end
        end
        a_settle();
        a_bp_en = 1'b1;
        e = {};
        for (int f = 0; f < 3; f++) begin
            d = {};
            for (int i = 0; i < NA; i++) d.push_back(8'($urandom));
            dm = 1'($urandom_range(0, 1));
            a_frame(d, dm);
            x = model(d, RA, CA, dm & DEINT_ON);
            for (int i = 0; i < NA; i++) e.push_back(x[i]);
        end
        a_wait(3 * NA, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL random_count got %0d required %0d", qa_d.size(), 3 * NA); end
        else for (int k = 0; k < 3 * NA; k++) begin
            n_checks++; if (qa_d[k] !== e[k] || qa_l[k] !== ((k % NA) == NA - 1)) begin n_fail++; $display("FAIL random_data k=%0d got %h/%b required %h/%b", k, qa_d[k], qa_l[k], e[k], (k % NA) == NA - 1); end
        end
        a_bp_en = 1'b0;
    endtask

    task automatic test_legacy_bits();
        logic [7:0] bits_in [NA] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1, 8'd0, 8'd1};
        logic [7:0] bits_out [NA] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1};
        bit to;
        a_settle();
        for (int i = 0; i < NA; i++) a_send(bits_in[i], 1'b0);
        a_wait(NA, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL legacy_count got %0d required %0d", qa_d.size(), NA); end
        else for (int k = 0; k < NA; k++) begin
            n_checks++; if (qa_d[k] !== bits_out[k]) begin n_fail++; $display("FAIL legacy_bits k=%0d got %h required %h", k, qa_d[k], bits_out[k]); end
        end
    endtask

    task automatic test_deint();
        sym_q_t d, e;
        bit to;
        d = {8'd0, 8'd4, 8'd1, 8'd5, 8'd2, 8'd6, 8'd3, 8'd7};
        e = model(d, RA, CA, DEINT_ON);
        a_settle();
        a_frame(d, 1'b1);
        a_wait(NA, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL deint_count got %0d required %0d", qa_d.size(), NA); end
        else for (int k = 0; k < NA; k++) begin
            n_checks++; if (qa_d[k] !== e[k]) begin n_fail++; $display("FAIL deint_data k=%0d got %h required %h", k, qa_d[k], e[k]); end
        end
    endtask

    task automatic test_backpressure();
        sym_q_t d, e, x;
        logic [7:0] held;
        bit to;
        a_settle();
        a_rdy_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = {};
        for (int f = 0; f < 2; f++) begin
            d = {};
            for (int i = 0; i < NA; i++) d.push_back(8'($urandom));
            for (int i = 0; i < NA; i++) a_send(d[i], 1'b0);
            x = model(d, RA, CA, 1'b0);
            for (int i = 0; i < NA; i++) e.push_back(x[i]);
        end
        held = e[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c=%0d got %b required 0", c, a_in_ready); end
            n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== held) begin n_fail++; $display("FAIL bp_hold c=%0d got %b/%h required 1/%h", c, a_out_valid, a_out_data, held); end
        end
        a_rdy_force = 1'b1;
        a_wait(2 * NA, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL bp_count got %0d required %0d", qa_d.size(), 2 * NA); end
        else for (int k = 0; k < 2 * NA; k++) begin
            n_checks++; if (qa_d[k] !== e[k]) begin n_fail++; $display("FAIL bp_data k=%0d got %h required %h", k, qa_d[k], e[k]); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp_out [NA] = '{8'd8, 8'd12, 8'd9, 8'd13, 8'd10, 8'd14, 8'd11, 8'd15};
        bit to;
        a_settle();
        for (int i = 0; i < 3; i++) a_send(8'($urandom), 1'b0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        qa_d.delete(); qa_l.delete();
        n_checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_state got ready=%b valid=%b required 1/0", a_in_ready, a_out_valid); end
        for (int i = 0; i < NA; i++) a_send(8'(8 + i), 1'b0);
        a_wait(NA, to);
        repeat (30) @(negedge clk);
        n_checks++;
        if (to || qa_d.size() != NA) begin n_fail++; $display("FAIL midreset_count got %0d required %0d", qa_d.size(), NA); end
        else for (int k = 0; k < NA; k++) begin
            n_checks++; if (qa_d[k] !== exp_out[k]) begin n_fail++; $display("FAIL midreset_data k=%0d got %h required %h", k, qa_d[k], exp_out[k]); end
        end
    endtask

    task automatic test_back_to_back();
        sym_q_t d, e, x;
        int w;
        int t = 0;
        repeat (5) @(posedge clk);
        #1;
        qb_d.delete(); qb_l.delete(); qb_c.delete();
        e = {};
        for (int f = 0; f < 4; f++) begin
            d = {};
            for (int i = 0; i < NB; i++) d.push_back((f == 0) ? 8'(i) : 8'($urandom));
            for (int i = 0; i < NB; i++) begin
                b_send(d[i], w);
                if (f > 0) begin
                    n_checks++; if (w != 0) begin n_fail++; $display("FAIL b2b_in_ready f=%0d i=%0d got %0d stall cycles required 0", f, i, w); end
                end
            end
            x = model(d, RB, CB, 1'b0);
            for (int i = 0; i < NB; i++) e.push_back(x[i]);
        end
        while (qb_d.size() < 4 * NB && t < 2000) begin @(negedge clk); t++; end
        n_checks++;
        if (qb_d.size() < 4 * NB) begin n_fail++; $display("FAIL b2b_count got %0d required %0d", qb_d.size(), 4 * NB); end
        else for (int k = 0; k < 4 * NB; k++) begin
            n_checks++; if (qb_d[k] !== e[k] || qb_l[k] !== ((k % NB) == NB - 1)) begin n_fail++; $display("FAIL b2b_data k=%0d got %h/%b required %h/%b", k, qb_d[k], qb_l[k], e[k], (k % NB) == NB - 1); end
            if (k > 0) begin
                n_checks++; if (qb_c[k] != qb_c[k-1] + 1) begin n_fail++; $display("FAIL b2b_rate k=%0d got gap %0d required 1", k, qb_c[k] - qb_c[k-1]); end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        a_in_data = 8'h00; a_in_valid = 1'b0; a_deint = 1'b0;
        b_in_data = 8'h00; b_in_valid = 1'b0; b_deint = 1'b0;
        test_reset();
        test_interleave();
        test_legacy_bits();
        test_deint();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
